// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: load/store access encodings, LSU state type and alignment helper
package riscv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} lsu_state_t;
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering with byte enables, load lane extraction with sign/zero extension
module lsu_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] wdata_lane,
  output logic [3:0]      wstrb,
  input  logic [XLEN-1:0] rdata_word,
  output logic [XLEN-1:0] rdata_ext
);
  logic [15:0] sh;
  always_comb begin
    sh = 16'(rdata_word >> {off, 3'b000});
    wdata_lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    wstrb = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    rdata_ext = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh} :
                funct3 == F3_BU ? {24'b0, sh[7:0]} :
                funct3 == F3_HU ? {16'b0, sh} : rdata_word;
  end
endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit running a valid/ready bus transaction and stalling the core until it completes
module lsu_bus_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            err,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rdata
);
  lsu_state_t state;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic to_q;
  logic [15:0] cnt;
  logic req, bad, acc;
  logic [XLEN-1:0] wd_lane, rd_ext;
  logic [3:0] strb;
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (state == IDLE ? funct3 : f3_q),
    .off        (state == IDLE ? addr[1:0] : off_q),
    .wdata      (wdata),
    .wdata_lane (wd_lane),
    .wstrb      (strb),
    .rdata_word (bus_rdata),
    .rdata_ext  (rd_ext)
  );
  always_comb begin
    req = mem_read | mem_write;
    bad = (mem_read & mem_write)
        | (mem_write ? !(funct3 inside {F3_B, F3_H, F3_W}) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
        | is_misaligned(funct3, addr[1:0]);
    acc = state == IDLE && req && !bad;
    stall = acc || state == REQ || state == WAIT_RSP;
    err = (state == IDLE && req && bad) || (state == DONE && to_q);
    done = state == DONE;
    bus_req_valid = state == REQ;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      to_q      <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          state     <= REQ;
          f3_q      <= funct3;
          off_q     <= addr[1:0];
          bus_we    <= mem_write;
          bus_addr  <= {addr[XLEN-1:2], 2'b00};
          bus_wdata <= mem_write ? wd_lane : '0;
          bus_wstrb <= mem_write ? strb : 4'b0000;
        end
        REQ: if (bus_req_ready) begin
          state <= WAIT_RSP;
          cnt   <= '0;
        end
        WAIT_RSP: if (bus_rsp_valid) begin
          state <= DONE;
          to_q  <= 1'b0;
          rdata <= bus_we ? '0 : rd_ext;
        end else if (cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
          state <= DONE;
          to_q  <= 1'b1;
          rdata <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: vector table, random transactions against a lane-arithmetic model, timeout and reset sequences
module tb_lsu_bus_ctrl;
  import riscv_mem_pkg::*;
  logic clk, rst_n, mem_read, mem_write, stall, done, err;
  logic bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
  logic [2:0] funct3;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_wstrb;
  int tests = 0;
  int fails = 0;
  lsu_bus_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .done(done), .err(err), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, wd, brd;
    logic bad;
    logic [3:0] strb;
    logic [31:0] bwd, rdv;
    int rdy, rsp;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] brd, output logic bad,
                                output logic [3:0] strb, output logic [31:0] bwd, output logic [31:0] rdv);
    int sz, off;
    logic [31:0] val, mask;
    sz = 1 << f3[1:0];
    off = int'(a[1:0]);
    bad = (rd && wr) || (wr && !(f3 inside {0, 1, 2})) || (rd && !(f3 inside {0, 1, 2, 4, 5})) || (off % sz != 0);
    strb = 4'b0000;
    bwd = 32'h0;
    rdv = 32'h0;
    if (wr)
      for (int i = 0; i < 4; i++) begin
        bwd[8*i +: 8] = wd[8*(i % sz) +: 8];
        strb[i] = (i >= off && i < off + sz);
      end
    else begin
      val = brd >> (8 * off);
      if (sz < 4) begin
        mask = (32'h1 << (8 * sz)) - 32'h1;
        val = val & mask;
        if (!f3[2] && val[8*sz-1]) val = val | ~mask;
      end
      rdv = val;
    end
  endfunction
  task automatic txn(input vec_t t);
    mem_read = t.rd; mem_write = t.wr; funct3 = t.f3; addr = t.a; wdata = t.wd;
    @(negedge clk);
    if (t.bad) begin
      chk("rej_err", err, 1);
      chk("rej_stall", stall, 0);
      chk("rej_req", bus_req_valid, 0);
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
      return;
    end
    chk("acc_stall", stall, 1);
    chk("acc_err", err, 0);
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    for (int i = 0; i <= t.rdy; i++) begin
      bus_req_ready = (i == t.rdy);
      @(negedge clk);
      chk("req_valid", bus_req_valid, 1);
      chk("req_addr", bus_addr, {t.a[31:2], 2'b00});
      chk("req_we", bus_we, t.wr);
      chk("req_strb", bus_wstrb, t.strb);
      if (t.wr) chk("req_wdata", bus_wdata, t.bwd);
      chk("req_stall", stall, 1);
      chk("req_done", done, 0);
      @(posedge clk); #1;
    end
    bus_req_ready = 0;
    for (int i = 0; i <= t.rsp; i++) begin
      bus_rsp_valid = (i == t.rsp);
      bus_rdata = (i == t.rsp) ? t.brd : $urandom;
      @(negedge clk);
      chk("wait_stall", stall, 1);
      chk("wait_done", done, 0);
      chk("wait_req", bus_req_valid, 0);
      @(posedge clk); #1;
    end
    bus_rsp_valid = 0;
    @(negedge clk);
    chk("done", done, 1);
    chk("done_err", err, 0);
    chk("done_stall", stall, 0);
    chk("done_rdata", rdata, t.rdv);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_done", done, 0);
    @(posedge clk); #1;
  endtask
  task automatic start_acc(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    mem_read = !wr; mem_write = wr; funct3 = F3_W; addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; bus_req_ready = 1;
    @(posedge clk); #1;
    bus_req_ready = 0;
  endtask
  initial begin
    vec_t t;
    int op;
    rst_n = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
    v[0]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 0};
    v[1]  = '{1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'h0080FF00, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80, 0, 0};
    v[2]  = '{1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 32'h0080FF00, 1'b0, 4'b0000, 32'h0, 32'h00000080, 1, 0};
    v[3]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h0080FF00, 1'b0, 4'b0000, 32'h0, 32'h00000080, 0, 1};
    v[4]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80001234, 1'b0, 4'b0000, 32'h0, 32'hFFFF8000, 0, 2};
    v[5]  = '{1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 0};
    v[6]  = '{1'b0, 1'b1, 3'b001, 32'h001, 32'hFFFF, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 0};
    v[7]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF, 5, 0};
    v[8]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0, 0, 3};
    v[9]  = '{1'b0, 1'b1, 3'b010, 32'h010, 32'h12345678, 32'h0, 1'b0, 4'b1111, 32'h12345678, 32'h0, 2, 1};
    v[10] = '{1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 0};
    v[11] = '{1'b0, 1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 0};
    v[12] = '{1'b1, 1'b1, 3'b010, 32'h000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 0};
    v[13] = '{1'b1, 1'b0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 1'b0, 4'b0000, 32'h0, 32'h0000007F, 0, 0};
    v[14] = '{1'b1, 1'b0, 3'b001, 32'h003, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ctl", {23'b0, stall, done, err, bus_req_valid, bus_we, bus_wstrb}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 15; i++) txn(v[i]);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      t.rd = (op <= 5);
      t.wr = (op == 0 || op >= 6);
      t.f3 = 3'($urandom);
      t.a = $urandom;
      t.wd = $urandom;
      t.brd = $urandom;
      t.rdy = $urandom_range(0, 3);
      t.rsp = $urandom_range(0, 3);
      model(t.rd, t.wr, t.f3, t.a, t.wd, t.brd, t.bad, t.strb, t.bwd, t.rdv);
      txn(t);
    end
    txn(v[7]);
    start_acc(1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_stall", stall, 1);
      chk("to_early_done", done, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    @(posedge clk); #1;
    bus_rsp_valid = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_rsp_done", done, 0);
    @(posedge clk); #1;
    bus_rsp_valid = 0;
    @(negedge clk);
    chk("late_rsp_done2", {done, err, stall}, 0);
    chk("late_rsp_rdata", rdata, 0);
    @(posedge clk); #1;
    t = v[7]; t.brd = 32'h13579BDF; t.rdv = 32'h13579BDF; t.rdy = 0;
    txn(t);
    start_acc(1'b1, 32'h40, 32'h55);
    rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_ctl", {23'b0, stall, done, err, bus_req_valid, bus_we, bus_wstrb}, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_addr", bus_addr, 0);
    chk("mrst_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1; bus_rsp_valid = 1;
    @(negedge clk);
    chk("mrst_rsp_done", done, 0);
    @(posedge clk); #1;
    bus_rsp_valid = 0;
    @(negedge clk);
    chk("mrst_rsp_done2", {done, stall}, 0);
    @(posedge clk); #1;
    txn(v[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
